// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - inter-stage pipeline register with valid/ready handshake, 2-entry skid, flush and bubbles
// Define STAGE_STAT_EN to add saturating stall_cnt/flush_cnt counters (parameter CNT_W).
module pipe_stage_reg #(
    parameter int CTRL_W = 12,
    parameter int DATA_W = 101,
    parameter int PC_W   = 32,
    parameter int PC_INC = 4
`ifdef STAGE_STAT_EN
   ,parameter int CNT_W  = 16
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    input  logic [PC_W-1:0]   in_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [PC_W-1:0]   out_pc
`ifdef STAGE_STAT_EN
   ,output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
`endif
);

    localparam logic [PC_W-1:0] PC_INC_V = PC_W'(PC_INC);

    logic              main_valid_q, main_valid_d;
    logic [CTRL_W-1:0] main_ctrl_q,  main_ctrl_d;
    logic [DATA_W-1:0] main_data_q,  main_data_d;
    logic [PC_W-1:0]   main_pc_q,    main_pc_d;

    logic              skid_valid_q, skid_valid_d;
    logic [CTRL_W-1:0] skid_ctrl_q,  skid_ctrl_d;
    logic [DATA_W-1:0] skid_data_q,  skid_data_d;
    logic [PC_W-1:0]   skid_pc_q,    skid_pc_d;

    logic            acc;
    logic            drn;
    logic [PC_W-1:0] cap_pc;

    // in_ready depends only on registered state, so out_ready never reaches it combinationally
    assign in_ready = !skid_valid_q;
    assign acc      = in_valid && in_ready;
    assign drn      = main_valid_q && out_ready;
    assign cap_pc   = in_pc + PC_INC_V;

    always_comb begin
        main_valid_d = main_valid_q;
        main_ctrl_d  = main_ctrl_q;
        main_data_d  = main_data_q;
        main_pc_d    = main_pc_q;
        skid_valid_d = skid_valid_q;
        skid_ctrl_d  = skid_ctrl_q;
        skid_data_d  = skid_data_q;
        skid_pc_d    = skid_pc_q;

        if (flush) begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else if (acc && (!main_valid_q || drn)) begin
            main_valid_d = 1'b1;
            main_ctrl_d  = in_ctrl;
            main_data_d  = in_data;
            main_pc_d    = cap_pc;
        end else if (acc) begin
            // main is stalled: park the younger entry behind it
            skid_valid_d = 1'b1;
            skid_ctrl_d  = in_ctrl;
            skid_data_d  = in_data;
            skid_pc_d    = cap_pc;
        end else if (drn && skid_valid_q) begin
            main_valid_d = 1'b1;
            main_ctrl_d  = skid_ctrl_q;
            main_data_d  = skid_data_q;
            main_pc_d    = skid_pc_q;
            skid_valid_d = 1'b0;
        end else if (drn) begin
            main_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            main_valid_q <= 1'b0;
            main_ctrl_q  <= '0;
            main_data_q  <= '0;
            main_pc_q    <= '0;
            skid_valid_q <= 1'b0;
            skid_ctrl_q  <= '0;
            skid_data_q  <= '0;
            skid_pc_q    <= '0;
        end else begin
            main_valid_q <= main_valid_d;
            main_ctrl_q  <= main_ctrl_d;
            main_data_q  <= main_data_d;
            main_pc_q    <= main_pc_d;
            skid_valid_q <= skid_valid_d;
            skid_ctrl_q  <= skid_ctrl_d;
            skid_data_q  <= skid_data_d;
            skid_pc_q    <= skid_pc_d;
        end
    end

    // Bubbles present all-zero control so no write enable can leak downstream
    assign out_valid = main_valid_q;
    assign out_ctrl  = main_valid_q ? main_ctrl_q : '0;
    assign out_data  = main_data_q;
    assign out_pc    = main_pc_q;

`ifdef STAGE_STAT_EN
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] flush_cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (main_valid_q && !out_ready && stall_cnt_q != CNT_MAX) begin
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            end
            if (flush && (main_valid_q || skid_valid_q) && flush_cnt_q != CNT_MAX) begin
                flush_cnt_q <= flush_cnt_q + CNT_W'(1);
            end
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb/tb_pipe_stage_reg.sv - randomized self-checking bench for pipe_stage_reg against a queue model
// Counter checks are compiled in when STAGE_STAT_EN is defined.
module tb_pipe_stage_reg;

    localparam int CTRL_W = 12;
    localparam int DATA_W = 101;
    localparam int PC_W   = 32;
    localparam int PC_INC = 4;
`ifdef STAGE_STAT_EN
    localparam int          TB_CNT_W = 8;
    localparam int unsigned CNT_MAX  = (1 << TB_CNT_W) - 1;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              flush = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [CTRL_W-1:0] in_ctrl = '0;
    logic [DATA_W-1:0] in_data = '0;
    logic [PC_W-1:0]   in_pc = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [CTRL_W-1:0] out_ctrl;
    logic [DATA_W-1:0] out_data;
    logic [PC_W-1:0]   out_pc;
`ifdef STAGE_STAT_EN
    logic [TB_CNT_W-1:0] stall_cnt;
    logic [TB_CNT_W-1:0] flush_cnt;
    int unsigned         m_stall = 0;
    int unsigned         m_flush = 0;
`endif

    always #5 clk = ~clk;

    pipe_stage_reg #(
        .CTRL_W(CTRL_W), .DATA_W(DATA_W), .PC_W(PC_W), .PC_INC(PC_INC)
`ifdef STAGE_STAT_EN
       ,.CNT_W(TB_CNT_W)
`endif
    ) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_ctrl(in_ctrl), .in_data(in_data), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_ctrl(out_ctrl), .out_data(out_data), .out_pc(out_pc)
`ifdef STAGE_STAT_EN
       ,.stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
    );

    typedef struct packed {
        logic [CTRL_W-1:0] c;
        logic [DATA_W-1:0] d;
        logic [PC_W-1:0]   p;
    } ent_t;

    ent_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [DATA_W-1:0] rand_data();
        logic [127:0] r;
        r = {$urandom, $urandom, $urandom, $urandom};
        return r[DATA_W-1:0];
    endfunction

    // In-order FIFO of at most two instructions; ready whenever fewer than two are held
    task automatic model_edge();
        int   sz;
        bit   acc;
        bit   drn;
        ent_t e;
        sz = q.size();
`ifdef STAGE_STAT_EN
        if (sz > 0 && !out_ready && m_stall < CNT_MAX) m_stall++;
        if (flush && sz > 0 && m_flush < CNT_MAX) m_flush++;
`endif
        if (flush) begin
            q.delete();
        end else begin
            acc = in_valid && (sz < 2);
            drn = (sz > 0) && out_ready;
            if (drn) void'(q.pop_front());
            if (acc) begin
                e.c = in_ctrl;
                e.d = in_data;
                e.p = in_pc + 32'(PC_INC);
                q.push_back(e);
            end
        end
    endtask

    task automatic compare();
        chk("out_valid", 128'(out_valid), 128'(q.size() > 0));
        chk("in_ready", 128'(in_ready), 128'(q.size() < 2));
        if (q.size() > 0) begin
            chk("out_ctrl", 128'(out_ctrl), 128'(q[0].c));
            chk("out_data", 128'(out_data), 128'(q[0].d));
            chk("out_pc", 128'(out_pc), 128'(q[0].p));
        end else begin
            chk("bubble_ctrl", 128'(out_ctrl), 128'(0));
        end
`ifdef STAGE_STAT_EN
        chk("stall_cnt", 128'(stall_cnt), 128'(m_stall));
        chk("flush_cnt", 128'(flush_cnt), 128'(m_flush));
`endif
    endtask

    task automatic step(input logic v, input logic rdy, input logic fl,
                        input logic [CTRL_W-1:0] c, input logic [PC_W-1:0] p);
        in_valid  = v;
        out_ready = rdy;
        flush     = fl;
        in_ctrl   = c;
        in_data   = rand_data();
        in_pc     = p;
        @(posedge clk);
        model_edge();
        #1;
        compare();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset held with upstream offering data
        rst = 1'b0; in_valid = 1'b1; in_pc = 32'h100; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 128'(out_valid), 128'(0));
        chk("rst_out_ctrl", 128'(out_ctrl), 128'(0));
        chk("rst_out_pc", 128'(out_pc), 128'(0));
        chk("rst_out_data", 128'(out_data), 128'(0));
        chk("rst_in_ready", 128'(in_ready), 128'(1));
        rst = 1'b1;
        step(1, 1, 0, 12'h001, 32'h100);
        chk("first_pc", 128'(out_pc), 128'h104);

        // Streaming
        step(1, 1, 0, 12'h011, 32'h0);
        chk("stream_pc0", 128'(out_pc), 128'h4);
        step(1, 1, 0, 12'h022, 32'h4);
        chk("stream_pc1", 128'(out_pc), 128'h8);
        step(1, 1, 0, 12'h033, 32'h8);
        chk("stream_pc2", 128'(out_pc), 128'hC);
        chk("stream_ready", 128'(in_ready), 128'(1));
        step(0, 1, 0, 12'h0, 32'h0);

        // Backpressure fills the skid, then drains in order
        step(1, 0, 0, 12'hABC, 32'h10);
        step(1, 0, 0, 12'h123, 32'h14);
        chk("bp_in_ready", 128'(in_ready), 128'(0));
        chk("bp_first", 128'(out_ctrl), 128'hABC);
        step(1, 0, 0, 12'h777, 32'h18);
        chk("bp_hold", 128'(out_ctrl), 128'hABC);
        step(0, 1, 0, 12'h0, 32'h0);
        chk("bp_second", 128'(out_ctrl), 128'h123);
        chk("bp_ready_after", 128'(in_ready), 128'(1));
        step(0, 1, 0, 12'h0, 32'h0);

        // Flush with the skid full and input offered
        step(1, 0, 0, 12'h111, 32'h20);
        step(1, 0, 0, 12'h222, 32'h24);
        step(1, 0, 1, 12'h5A5, 32'h28);
        chk("flush_valid", 128'(out_valid), 128'(0));
        chk("flush_ctrl", 128'(out_ctrl), 128'(0));
        chk("flush_ready", 128'(in_ready), 128'(1));
        step(0, 1, 0, 12'h0, 32'h0);
        chk("flush_no_leak", 128'(out_valid), 128'(0));

        // Flush while an accept is taking place: that input is dropped
        step(1, 0, 0, 12'h333, 32'h30);
        step(1, 1, 1, 12'h444, 32'h34);
        chk("flush_acc_drop", 128'(out_valid), 128'(0));

        // PC wrap and bubble control
        step(1, 1, 0, 12'hFFF, 32'hFFFF_FFFC);
        chk("wrap_pc", 128'(out_pc), 128'h0);
        step(0, 1, 0, 12'hFFF, 32'h0);
        chk("bubble_valid", 128'(out_valid), 128'(0));
        chk("bubble_ctrl0", 128'(out_ctrl), 128'(0));

        // Asynchronous reset mid-operation
        step(1, 0, 0, 12'h0AA, 32'h40);
        step(1, 0, 0, 12'h0BB, 32'h44);
        #3 rst = 1'b0;
        #1;
        q.delete();
`ifdef STAGE_STAT_EN
        m_stall = 0;
        m_flush = 0;
`endif
        compare();
        chk("async_rst_pc", 128'(out_pc), 128'(0));
        #2 rst = 1'b1;

`ifdef STAGE_STAT_EN
        step(1, 0, 0, 12'h0CC, 32'h50);
        repeat (5) step(0, 0, 0, 12'h0, 32'h0);
        step(0, 1, 1, 12'h0, 32'h0);
        chk("stat_stall5", 128'(stall_cnt), 128'(5));
        chk("stat_flush1", 128'(flush_cnt), 128'(1));
        step(1, 0, 0, 12'h0DD, 32'h60);
        repeat (CNT_MAX + 20) step(0, 0, 0, 12'h0, 32'h0);
        chk("stat_sat", 128'(stall_cnt), 128'(CNT_MAX));
        step(0, 1, 1, 12'h0, 32'h0);
`endif

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 1) == 1, $urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0,
                 CTRL_W'($urandom), $urandom);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
